// File: rtl/instr_fetch.sv
// instr_fetch: owns the fetch PC, issues single-outstanding requests to instruction
//   memory, buffers returned bytes with their PC in a DEPTH-entry prefetch FIFO.
// Latency: first instr_valid one cycle after imem_rvalid (same cycle with IFETCH_BYPASS_EN).
// Backpressure: no request while the FIFO is full or a response is pending; decode stalls
//   via instr_ready. A taken branch (pc_src) flushes the FIFO and any in-flight response.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   imem_req/imem_addr/imem_gnt   request/grant handshake to instruction memory
//   imem_rvalid/imem_rdata        read response (at least one cycle after grant)
//   instr/instr_pc/instr_valid    FIFO head toward decode, consumed when instr_ready
//   pc_src/branch_target          taken-branch redirect, highest priority
//
// Optional feature macro: IFETCH_BYPASS_EN
//   When defined, a response arriving into an empty FIFO is presented to decode in
//   the same cycle; it is only written into the FIFO if decode does not take it.

module instr_fetch #(
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [7:0]        imem_rdata,
    output logic [7:0]        instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              pc_src,
    input  logic [ADDR_W-1:0] branch_target
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_RESP  = 2'd1,
        ST_FLUSH_WAIT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;

    logic [7:0]        fifo_instr_q [DEPTH];
    logic [ADDR_W-1:0] fifo_pc_q    [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic fifo_full, fifo_empty;
    logic grant, push, pop, bypass;

    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign fifo_empty = (count_q == '0);

    // Request is gated by reset so nothing escapes while rst_n is low, and masked by
    // pc_src so a branch cycle can never be granted with the stale fpc.
    assign imem_req  = rst_n && (state_q == ST_IDLE) && !fifo_full && !pc_src;
    assign imem_addr = fpc_q;
    assign grant     = imem_req && imem_gnt;

`ifdef IFETCH_BYPASS_EN
    // Only a live response into an empty FIFO is forwarded; flushed responses never are.
    assign bypass      = (state_q == ST_WAIT_RESP) && fifo_empty && imem_rvalid && !pc_src;
    assign instr       = bypass ? imem_rdata : fifo_instr_q[rd_ptr_q];
    assign instr_pc    = bypass ? req_pc_q   : fifo_pc_q[rd_ptr_q];
    assign instr_valid = !fifo_empty || bypass;
`else
    assign bypass      = 1'b0;
    assign instr       = fifo_instr_q[rd_ptr_q];
    assign instr_pc    = fifo_pc_q[rd_ptr_q];
    assign instr_valid = !fifo_empty;
`endif

    // FIFO pop only when it holds data; a bypassed byte is consumed without touching it.
    // Any pop in a branch cycle is discarded because the FIFO is cleared anyway.
    assign pop = !fifo_empty && instr_ready && !pc_src;

    always_comb begin
        state_d  = state_q;
        fpc_d    = fpc_q;
        req_pc_d = req_pc_q;
        push     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    req_pc_d = fpc_q;
                    fpc_d    = fpc_q + ADDR_W'(1);
                    state_d  = ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                if (pc_src) begin
                    // Response in the branch cycle is simply dropped; otherwise it is
                    // still in flight and must be swallowed later.
                    state_d = imem_rvalid ? ST_IDLE : ST_FLUSH_WAIT;
                end else if (imem_rvalid) begin
                    // Slot is free: a request is only issued while count < DEPTH.
                    push    = !(bypass && instr_ready);
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH_WAIT: begin
                if (imem_rvalid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (pc_src) begin
            fpc_d = branch_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            fpc_q    <= RESET_PC;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            fpc_q    <= fpc_d;
            req_pc_q <= req_pc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc_q[i]    <= '0;
            end
        end else if (pc_src) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_instr_q[wr_ptr_q] <= imem_rdata;
                fifo_pc_q[wr_ptr_q]    <= req_pc_q;
                wr_ptr_q               <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: drives instr_fetch with a memory responder and decode sink, and
//   compares every cycle against a stream-level model: addresses are fetched in order
//   from the current stream start, decode sees pc/byte pairs in the same order, and a
//   taken branch restarts both streams at the target and discards anything in flight.

module tb_instr_fetch;

    localparam int         ADDR_W   = 8;
    localparam int         DEPTH    = 2;
    localparam logic [7:0] RESET_PC = 8'h00;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [7:0]        imem_rdata;
    logic [7:0]        instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              pc_src;
    logic [ADDR_W-1:0] branch_target;

    always #5 clk = ~clk;

    instr_fetch #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .pc_src       (pc_src),
        .branch_target(branch_target)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Stream model
    logic [7:0] exp_fetch;   // next address that should be requested
    logic [7:0] exp_pc;      // next pc decode should receive
    int         held;        // bytes fetched and accepted but not yet consumed
    bit         outstanding; // a granted request has not yet been answered
    bit         drop_resp;   // the outstanding response belongs to a flushed stream
    logic [7:0] out_addr;
    int         wait_cnt;    // cycles before the responder answers
    bit         force_ff;    // answer the outstanding request with 8'hFF
    bit         stale_rvalid;
    int         lat_min = 1;
    int         lat_max = 1;
    int         gnt_pct = 100;
    int         dut_grants;
    int         dut_pops;

    function automatic logic [7:0] memf(input logic [7:0] a);
        return a + 8'h10;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit rv, deliver, byp, exp_req, exp_vld, pop_now;
        imem_gnt    = ($urandom_range(1, 100) <= gnt_pct);
        rv          = (outstanding && wait_cnt == 0) || stale_rvalid;
        imem_rvalid = rv;
        if (stale_rvalid)  imem_rdata = 8'hEE;
        else if (!rv)      imem_rdata = 8'($urandom);
        else if (force_ff) imem_rdata = 8'hFF;
        else               imem_rdata = memf(out_addr);

        @(negedge clk);
        if (!rst_n) begin
            chk("rst_req",   32'(imem_req),    32'd0);
            chk("rst_valid", 32'(instr_valid), 32'd0);
            chk("rst_instr", 32'(instr),       32'd0);
            chk("rst_pc",    32'(instr_pc),    32'd0);
        end else begin
            deliver = outstanding && wait_cnt == 0;
            exp_req = !outstanding && held < DEPTH && !pc_src;
`ifdef IFETCH_BYPASS_EN
            byp = deliver && !drop_resp && held == 0 && !pc_src;
`else
            byp = 1'b0;
`endif
            exp_vld = (held != 0) || byp;

            chk("req", 32'(imem_req), 32'(exp_req));
            if (exp_req) chk("addr", 32'(imem_addr), 32'(exp_fetch));
            chk("valid", 32'(instr_valid), 32'(exp_vld));
            if (exp_vld) begin
                chk("instr_pc", 32'(instr_pc), 32'(exp_pc));
                chk("instr",    32'(instr),    32'(memf(exp_pc)));
            end
            if (imem_req && imem_gnt) dut_grants++;
            if (instr_valid && instr_ready && !pc_src) dut_pops++;

            pop_now = exp_vld && instr_ready && !pc_src;
            if (pc_src) begin
                held      = 0;
                exp_fetch = branch_target;
                exp_pc    = branch_target;
                if (outstanding && !deliver) drop_resp = 1'b1;
            end else begin
                if (pop_now) exp_pc = exp_pc + 8'd1;
                if (pop_now && !byp) held--;
                if (deliver && !drop_resp && !(byp && instr_ready)) held++;
            end
            if (deliver) begin
                outstanding = 1'b0;
                drop_resp   = 1'b0;
                force_ff    = 1'b0;
            end else if (outstanding) begin
                wait_cnt--;
            end
            if (exp_req && imem_gnt) begin
                outstanding = 1'b1;
                out_addr    = exp_fetch;
                exp_fetch   = exp_fetch + 8'd1;
                wait_cnt    = $urandom_range(lat_min, lat_max) - 1;
            end
        end
        stale_rvalid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        outstanding = 1'b0;
        drop_resp   = 1'b0;
        force_ff    = 1'b0;
        held        = 0;
        exp_fetch   = RESET_PC;
        exp_pc      = RESET_PC;
        dut_grants  = 0;
        dut_pops    = 0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        rst_n         = 1'b0;
        imem_gnt      = 1'b0;
        imem_rvalid   = 1'b0;
        imem_rdata    = 8'h00;
        instr_ready   = 1'b1;
        pc_src        = 1'b0;
        branch_target = 8'h00;
        stale_rvalid  = 1'b0;
        @(posedge clk);
        #1;

        // Streaming with grant always given and one-cycle response latency
        do_reset();
        repeat (12) tick();
        chk("t1_pops", 32'(dut_pops >= 4), 32'd1);

        // Decode stalled: FIFO fills, then requests stop
        do_reset();
        instr_ready = 1'b0;
        repeat (10) tick();
        chk("t2_grants", 32'(dut_grants), 32'd2);
        instr_ready = 1'b1;
        repeat (8) tick();
        chk("t2_resume", 32'(dut_grants >= 4), 32'd1);

        // Branch while waiting for the response to address 5
        do_reset();
        lat_min = 2;
        lat_max = 2;
        guard   = 0;
        while (!(outstanding && out_addr == 8'h05 && wait_cnt == 1) && guard < 100) begin
            tick();
            guard++;
        end
        chk("t3_reach", 32'(guard < 100), 32'd1);
        pc_src        = 1'b1;
        branch_target = 8'h40;
        force_ff      = 1'b1;
        tick();
        pc_src   = 1'b0;
        dut_pops = 0;
        repeat (10) tick();
        chk("t3_after", 32'(dut_pops > 0), 32'd1);

        // Branch in the same cycle the response arrives
        guard = 0;
        while (!(outstanding && wait_cnt == 0) && guard < 100) begin
            tick();
            guard++;
        end
        chk("t4_reach", 32'(guard < 100), 32'd1);
        pc_src        = 1'b1;
        branch_target = 8'h80;
        tick();
        pc_src = 1'b0;
        repeat (8) tick();

        // Fetch address wraps past the top of the address space
        lat_min       = 1;
        lat_max       = 1;
        pc_src        = 1'b1;
        branch_target = 8'hFE;
        tick();
        pc_src     = 1'b0;
        dut_grants = 0;
        repeat (12) tick();
        chk("t5_wrap", 32'(dut_grants >= 4), 32'd1);

        // Reset while a response is pending; a late response must be ignored
        guard = 0;
        while (!outstanding && guard < 100) begin
            tick();
            guard++;
        end
        chk("t6_reach", 32'(guard < 100), 32'd1);
        do_reset();
        stale_rvalid = 1'b1;
        tick();
        repeat (6) tick();

        // Random traffic: sporadic grants, variable latency, stalls and branches
        gnt_pct = 70;
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 800; i++) begin
            instr_ready   = ($urandom_range(0, 3) != 0);
            pc_src        = ($urandom_range(0, 19) == 0);
            branch_target = 8'($urandom);
            tick();
        end
        pc_src = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage that sits directly upstream of the decode controller.
- Owns the fetch PC and issues requests to the instruction memory over a request/grant + response handshake.
- Buffers returned 8-bit instructions in a small prefetch FIFO and presents them to decode with valid/ready.
- Redirects and flushes on a taken branch (pc_src / branch_target from the controller/ALU path).

Parameters:
- ADDR_W, 8, width of instruction address / PC.
- DEPTH, 2, prefetch FIFO entries; power of two, >= 2.
- RESET_PC, 0, fetch PC value after reset.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request, address valid
- imem_addr  out  ADDR_W  fetch address (= fpc)
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid, at least 1 cycle after grant
- imem_rdata  in  8  instruction byte
- instr  out  8  instruction to decode (FIFO head)
- instr_pc  out  ADDR_W  address of instr
- instr_valid  out  1  FIFO head valid
- instr_ready  in  1  decode consumes head
- pc_src  in  1  taken branch, redirect this cycle
- branch_target  in  ADDR_W  redirect address

Behaviour:
- Reset (async on rst_n low): state=IDLE, fpc=RESET_PC, FIFO count=0, instr_valid=0, imem_req=0 (gated low while rst_n low), instr/instr_pc=0.
- Accounting: FIFO stores {instr, pc}; pending=1 in WAIT_RESP only; at most one outstanding request.
- State IDLE:
  - imem_req = (count < DEPTH) && !pc_src; imem_addr=fpc.
  - On req && gnt: latch req_pc=fpc, fpc<=fpc+1 (mod 2^ADDR_W, wraps silently), go WAIT_RESP.
  - imem_req/imem_addr are not required to be held if not granted; fpc is unchanged until granted.
- State WAIT_RESP:
  - No request.
  - On imem_rvalid: push {imem_rdata, req_pc}, go IDLE. The slot is guaranteed free because a request is issued only when count < DEPTH.
- State FLUSH_WAIT:
  - No request.
  - On imem_rvalid: drop data, go IDLE.
- Pop: instr_valid && instr_ready removes head. Push and pop in the same cycle leave count unchanged.
- Branch (pc_src=1 at clock edge), priority over everything:
  - FIFO cleared (count=0); any pop that cycle is ignored.
  - fpc<=branch_target.
  - IDLE -> IDLE, with no grant possible because req is masked.
  - WAIT_RESP without rvalid -> FLUSH_WAIT.
  - WAIT_RESP with rvalid the same cycle -> data dropped, IDLE.
  - FLUSH_WAIT -> FLUSH_WAIT, or IDLE if rvalid that cycle.
  - instr_valid is 0 the cycle after a branch.
- Steady-state throughput: 1 instruction per (grant-to-rvalid latency + 1) cycles; the FIFO hides decode stalls.
- Mid-operation reset: all state returns to reset values immediately; a response arriving after reset release in IDLE is ignored.

Optional Feature:
- Macro: IFETCH_BYPASS_EN
- Defined: in WAIT_RESP with count==0 and imem_rvalid, instr/instr_pc/instr_valid are driven combinationally from imem_rdata/req_pc in the same cycle.
  - If instr_ready, the byte is not written to the FIFO.
  - Otherwise it is pushed as normal.
  - No bypass in FLUSH_WAIT or when pc_src=1.
- Undefined: responses always go through the FIFO; first instr_valid is 1 cycle after rvalid.

Test Plan:
- Reset release, gnt tied 1, rvalid 1 cycle after gnt, mem[i]=8'h10+i, ready=1 -> instr_pc 0,1,2… with instr 8'h10,8'h11,8'h12…; imem_req low during reset.
- ready=0 with DEPTH=2 -> exactly 2 grants (addr 0,1), then imem_req stays 0; count 2; raise ready -> 8'h10 then 8'h11 in order, then fetch resumes at addr 2.
- pc_src=1, branch_target=8'h40 while in WAIT_RESP for addr 5; rvalid next cycle with 8'hFF -> 8'hFF dropped, next request addr 8'h40, first instr_pc=8'h40.
- pc_src=1 in the same cycle as rvalid -> data dropped, state IDLE, no FLUSH_WAIT, next request addr = target.
- RESET_PC=8'hFE, ADDR_W=8 -> addresses FE, FF, 00, 01 (wrap).
- rst_n low while in WAIT_RESP, then rvalid after release -> response ignored, first request addr RESET_PC, instr_valid 0; with IFETCH_BYPASS_EN, an empty FIFO plus rvalid gives instr_valid in the same cycle as rvalid.
